// File: rtl/elevator_motion_ctrl_if.sv
// Request, tick and status signals between the elevator motion controller and its environment.
interface elevator_motion_ctrl_if #(
    parameter int unsigned FLOOR_W = 3
);
    logic               tick;
    logic               req_valid;
    logic [FLOOR_W-1:0] req_floor;
    logic               req_ready;
    logic               req_err;
    logic               estop;
    logic [1:0]         spd;
    logic [FLOOR_W-1:0] cur_floor;
    logic               dir;
    logic               moving;
    logic               door_open;
    logic               arrived;

    modport master (
        output tick, req_valid, req_floor, estop,
        input  req_ready, req_err, spd, cur_floor, dir, moving, door_open, arrived
    );

    modport slave (
        input  tick, req_valid, req_floor, estop,
        output req_ready, req_err, spd, cur_floor, dir, moving, door_open, arrived
    );
endinterface

// File: rtl/elevator_motion_ctrl.sv
// Elevator car motion controller: tick-counted positioning, linear speed ramp, door dwell, e-stop.
// Optional auto-park to floor 0 after a long idle period: define ELEV_AUTOPARK_EN.
module elevator_motion_ctrl #(
    parameter int unsigned FLOORS          = 8,
    parameter int unsigned FLOOR_W         = 3,
    parameter int unsigned TICKS_PER_FLOOR = 16,
    parameter int unsigned RAMP_TICKS      = 4,
    parameter int unsigned DOOR_CYCLES     = 100,
    parameter int unsigned PARK_CYCLES     = 1000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    elevator_motion_ctrl_if.slave  mc
);
    localparam int unsigned CNT_W  = $clog2(FLOORS * TICKS_PER_FLOOR + 1);
    localparam int unsigned PF_W   = $clog2(TICKS_PER_FLOOR + 1);
    localparam int unsigned DOOR_W = $clog2(DOOR_CYCLES + 1);
    localparam int unsigned FLW1   = FLOOR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR, S_ESTOP} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   ela_q, ela_d;
    logic [PF_W-1:0]    pf_q, pf_d;
    logic [DOOR_W-1:0]  door_cnt_q, door_cnt_d;
    logic [FLOOR_W-1:0] floor_q, floor_d;
    logic               dir_q, dir_d;
    logic [1:0]         spd_q, spd_d;
    logic               req_err_q, req_err_d;
    logic               arrived_q, req_ready_q, moving_q, door_open_q;

    logic               park_req_c;
    logic               req_go_c;
    logic [FLOOR_W-1:0] req_tgt_c;
    logic [FLOOR_W-1:0] dist_c;

`ifdef ELEV_AUTOPARK_EN
    localparam int unsigned PARK_W = $clog2(PARK_CYCLES + 1);
    logic [PARK_W-1:0] park_cnt_q;

    // Idle-time counter; the request fires on the cycle it reaches PARK_CYCLES.
    assign park_req_c = (state_q == S_IDLE) && (park_cnt_q == PARK_W'(PARK_CYCLES - 1))
                        && (floor_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            park_cnt_q <= '0;
        end else if ((state_q != S_IDLE) || (state_d != S_IDLE) || mc.req_valid) begin
            park_cnt_q <= '0;
        end else if (park_cnt_q != PARK_W'(PARK_CYCLES)) begin
            park_cnt_q <= park_cnt_q + PARK_W'(1);
        end
    end
`else
    assign park_req_c = 1'b0;
`endif

    // External request takes precedence over the internal park request.
    assign req_go_c  = (state_q == S_IDLE) && (mc.req_valid || park_req_c);
    assign req_tgt_c = mc.req_valid ? mc.req_floor : '0;
    assign dist_c    = (req_tgt_c > floor_q) ? (req_tgt_c - floor_q) : (floor_q - req_tgt_c);

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        ela_d      = ela_q;
        pf_d       = pf_q;
        door_cnt_d = door_cnt_q;
        floor_d    = floor_q;
        dir_d      = dir_q;
        req_err_d  = 1'b0;
        if (mc.estop) begin
            state_d    = S_ESTOP;
            door_cnt_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (req_go_c) begin
                        if ({1'b0, req_tgt_c} >= FLW1'(FLOORS)) begin
                            req_err_d = 1'b1;
                        end else if (req_tgt_c == floor_q) begin
                            state_d    = S_DOOR;
                            door_cnt_d = '0;
                        end else begin
                            state_d = S_MOVE;
                            dir_d   = (req_tgt_c > floor_q);
                            rem_d   = CNT_W'(dist_c) * CNT_W'(TICKS_PER_FLOOR);
                            ela_d   = '0;
                            pf_d    = '0;
                        end
                    end
                end
                S_MOVE: begin
                    if (mc.tick) begin
                        ela_d = ela_q + CNT_W'(1);
                        rem_d = rem_q - CNT_W'(1);
                        if (pf_q == PF_W'(TICKS_PER_FLOOR - 1)) begin
                            pf_d    = '0;
                            floor_d = dir_q ? (floor_q + FLOOR_W'(1)) : (floor_q - FLOOR_W'(1));
                        end else begin
                            pf_d = pf_q + PF_W'(1);
                        end
                        if (rem_q == CNT_W'(1)) begin
                            state_d    = S_DOOR;
                            door_cnt_d = '0;
                        end
                    end
                end
                S_DOOR: begin
                    if (door_cnt_q == DOOR_W'(DOOR_CYCLES - 1)) begin
                        state_d = S_IDLE;
                    end else begin
                        door_cnt_d = door_cnt_q + DOOR_W'(1);
                    end
                end
                S_ESTOP: begin
                    if (rem_q != '0) begin
                        state_d = S_MOVE;
                        ela_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Speed profile from the post-update counters so spd follows a tick by one cycle.
    logic [CNT_W-1:0] ramp_lvl_c;
    logic [1:0]       up_c, dn_c;

    always_comb begin
        ramp_lvl_c = ela_d / CNT_W'(RAMP_TICKS);
        up_c       = (ramp_lvl_c >= CNT_W'(2)) ? 2'd3 : ((ramp_lvl_c == CNT_W'(1)) ? 2'd2 : 2'd1);
        dn_c       = (rem_d > CNT_W'(2 * RAMP_TICKS)) ? 2'd3 :
                     ((rem_d > CNT_W'(RAMP_TICKS)) ? 2'd2 : 2'd1);
        spd_d      = (state_d == S_MOVE) ? ((up_c < dn_c) ? up_c : dn_c) : 2'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            ela_q       <= '0;
            pf_q        <= '0;
            door_cnt_q  <= '0;
            floor_q     <= '0;
            dir_q       <= 1'b0;
            spd_q       <= 2'd0;
            req_err_q   <= 1'b0;
            arrived_q   <= 1'b0;
            req_ready_q <= 1'b1;
            moving_q    <= 1'b0;
            door_open_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            ela_q       <= ela_d;
            pf_q        <= pf_d;
            door_cnt_q  <= door_cnt_d;
            floor_q     <= floor_d;
            dir_q       <= dir_d;
            spd_q       <= spd_d;
            req_err_q   <= req_err_d;
            arrived_q   <= (state_d == S_DOOR) && (state_q != S_DOOR);
            req_ready_q <= (state_d == S_IDLE);
            moving_q    <= (state_d == S_MOVE);
            door_open_q <= (state_d == S_DOOR);
        end
    end

    assign mc.spd       = spd_q;
    assign mc.cur_floor = floor_q;
    assign mc.dir       = dir_q;
    assign mc.req_ready = req_ready_q;
    assign mc.req_err   = req_err_q;
    assign mc.moving    = moving_q;
    assign mc.door_open = door_open_q;
    assign mc.arrived   = arrived_q;
endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// Directed bench for elevator_motion_ctrl with a position-in-ticks reference model.
module tb_elevator_motion_ctrl;
    localparam int FLOORS = 8;
    localparam int FW     = 4;
    localparam int TPF    = 16;
    localparam int RAMP   = 4;
    localparam int DOORC  = 100;
    localparam int PARK   = 1000;

    localparam int PH_IDLE = 0, PH_MOVE = 1, PH_DOOR = 2, PH_STOP = 3;

    logic clk, rst_n;
    int   n_total, n_pass;

    elevator_motion_ctrl_if #(.FLOOR_W(FW)) mc ();

    elevator_motion_ctrl #(
        .FLOORS(FLOORS), .FLOOR_W(FW), .TICKS_PER_FLOOR(TPF),
        .RAMP_TICKS(RAMP), .DOOR_CYCLES(DOORC), .PARK_CYCLES(PARK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mc(mc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: car position counted in ticks above floor 0.
    int m_phase, m_pos, m_tgt, m_el, m_door, m_idle;
    bit m_dir, m_arr, m_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = PH_IDLE; m_pos = 0; m_tgt = 0; m_el = 0; m_door = 0;
            m_idle = 0; m_dir = 0; m_arr = 0; m_err = 0;
        end else begin
            m_arr = 0;
            m_err = 0;
            if (mc.estop) begin
                m_phase = PH_STOP;
                m_idle  = 0;
            end else begin
                case (m_phase)
                    PH_IDLE: begin
                        int t;
                        bit go;
                        go = mc.req_valid;
                        t  = int'(mc.req_floor);
                        if (mc.req_valid) m_idle = 0;
                        else begin
                            m_idle++;
`ifdef ELEV_AUTOPARK_EN
                            if (m_idle == PARK && m_pos != 0) begin go = 1; t = 0; end
`endif
                        end
                        if (go) begin
                            if (t >= FLOORS) m_err = 1;
                            else if (t * TPF == m_pos) begin
                                m_phase = PH_DOOR; m_door = 0; m_arr = 1; m_idle = 0;
                            end else begin
                                m_tgt = t * TPF; m_dir = (m_tgt > m_pos); m_el = 0;
                                m_phase = PH_MOVE; m_idle = 0;
                            end
                        end
                    end
                    PH_MOVE: if (mc.tick) begin
                        m_pos += m_dir ? 1 : -1;
                        m_el++;
                        if (m_pos == m_tgt) begin m_phase = PH_DOOR; m_door = 0; m_arr = 1; end
                    end
                    PH_DOOR: begin
                        m_door++;
                        if (m_door == DOORC) m_phase = PH_IDLE;
                    end
                    default: begin
                        if (m_pos != m_tgt) begin m_phase = PH_MOVE; m_el = 0; end
                        else m_phase = PH_IDLE;
                        m_door = 0;
                    end
                endcase
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic cmp_all();
        int r, up, dn, es, ef;
        r  = (m_tgt > m_pos) ? (m_tgt - m_pos) : (m_pos - m_tgt);
        up = 1 + m_el / RAMP;
        if (up > 3) up = 3;
        dn = (r > 2 * RAMP) ? 3 : ((r > RAMP) ? 2 : 1);
        es = (m_phase == PH_MOVE) ? ((up < dn) ? up : dn) : 0;
        ef = m_dir ? (m_pos / TPF) : ((m_pos + TPF - 1) / TPF);
        chk("model_spd",       int'(mc.spd),       es);
        chk("model_cur_floor", int'(mc.cur_floor), ef);
        chk("model_dir",       int'(mc.dir),       int'(m_dir));
        chk("model_moving",    int'(mc.moving),    int'(m_phase == PH_MOVE));
        chk("model_door_open", int'(mc.door_open), int'(m_phase == PH_DOOR));
        chk("model_req_ready", int'(mc.req_ready), int'(m_phase == PH_IDLE));
        chk("model_arrived",   int'(mc.arrived),   int'(m_arr));
        chk("model_req_err",   int'(mc.req_err),   int'(m_err));
    endtask

    task automatic step();
        @(negedge clk);
        cmp_all();
    endtask

    task automatic do_ticks(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            mc.tick = 1'b1;
            step();
            mc.tick = 1'b0;
            repeat (gap - 1) step();
        end
    endtask

    task automatic request(input int fl);
        mc.req_valid = 1'b1;
        mc.req_floor = FW'(fl);
        step();
        mc.req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (!mc.req_ready && n < 400) begin step(); n++; end
        chk(nm, int'(mc.req_ready), 1);
    endtask

    initial begin
        int exp_spd, door_cnt, arr_cnt, err_cnt;
        n_total = 0; n_pass = 0;
        rst_n = 1'b0;
        mc.tick = 1'b0; mc.req_valid = 1'b0; mc.req_floor = '0; mc.estop = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_spd", int'(mc.spd), 0);
        chk("reset_floor", int'(mc.cur_floor), 0);
        chk("reset_ready", int'(mc.req_ready), 1);
        cmp_all();
        rst_n = 1'b1;
        step();

        // Floor 0 -> 2, one tick every 10 clocks.
        request(2);
        chk("a_moving", int'(mc.moving), 1);
        chk("a_dir_up", int'(mc.dir), 1);
        for (int k = 0; k < 32; k++) begin
            exp_spd = (k < 4) ? 1 : (k < 8) ? 2 : (k < 24) ? 3 : (k < 28) ? 2 : 1;
            chk($sformatf("a_spd_tick%0d", k), int'(mc.spd), exp_spd);
            if (k == 15) chk("a_floor_before16", int'(mc.cur_floor), 0);
            if (k == 16) chk("a_floor_after16", int'(mc.cur_floor), 1);
            do_ticks(1, (k == 31) ? 1 : 10);
        end
        chk("a_floor_final", int'(mc.cur_floor), 2);
        chk("a_spd_stop", int'(mc.spd), 0);
        door_cnt = 0; arr_cnt = 0;
        for (int i = 0; i < 200 && mc.door_open; i++) begin
            door_cnt++;
            if (mc.arrived) arr_cnt++;
            step();
        end
        chk("a_door_cycles", door_cnt, 100);
        chk("a_arrived_pulses", arr_cnt, 1);
        chk("a_idle_after_door", int'(mc.req_ready), 1);

        // Same-floor request, then out-of-range floor.
        request(2);
        chk("b_same_door", int'(mc.door_open), 1);
        chk("b_same_arrived", int'(mc.arrived), 1);
        chk("b_same_spd", int'(mc.spd), 0);
        wait_idle("b_same_idle");
        request(9);
        chk("b_err_pulse", int'(mc.req_err), 1);
        chk("b_err_idle", int'(mc.req_ready), 1);
        err_cnt = 0;
        for (int i = 0; i < 5; i++) begin step(); if (mc.req_err) err_cnt++; end
        chk("b_err_single", err_cnt, 0);

        // Requests during MOVE and DOOR are ignored.
        request(3);
        do_ticks(5, 2);
        chk("c_ready_move", int'(mc.req_ready), 0);
        request(7);
        do_ticks(11, 2);
        chk("c_target_kept", int'(mc.cur_floor), 3);
        chk("c_door", int'(mc.door_open), 1);
        request(0);
        wait_idle("c_idle");
        repeat (3) step();
        chk("c_not_moving", int'(mc.moving), 0);
        chk("c_floor_kept", int'(mc.cur_floor), 3);

        // Floor 3 -> 0 with emergency stop after 20 ticks; tick with estop is dropped.
        request(0);
        do_ticks(20, 3);
        mc.estop = 1'b1;
        mc.tick  = 1'b1;
        step();
        mc.tick = 1'b0;
        chk("d_estop_spd", int'(mc.spd), 0);
        chk("d_estop_moving", int'(mc.moving), 0);
        repeat (49) step();
        chk("d_estop_floor", int'(mc.cur_floor), 2);
        mc.estop = 1'b0;
        step();
        chk("d_resume_spd", int'(mc.spd), 1);
        chk("d_resume_moving", int'(mc.moving), 1);
        do_ticks(27, 3);
        chk("d_still_moving", int'(mc.moving), 1);
        do_ticks(1, 1);
        chk("d_arrived", int'(mc.arrived), 1);
        chk("d_floor0", int'(mc.cur_floor), 0);
        wait_idle("d_idle");

        // Asynchronous reset while running at full speed.
        request(5);
        do_ticks(8, 2);
        chk("e_full_speed", int'(mc.spd), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("e_rst_spd", int'(mc.spd), 0);
        chk("e_rst_moving", int'(mc.moving), 0);
        chk("e_rst_floor", int'(mc.cur_floor), 0);
        cmp_all();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("e_idle_after_rst", int'(mc.req_ready), 1);

`ifdef ELEV_AUTOPARK_EN
        request(4);
        do_ticks(64, 1);
        wait_idle("f_idle_at4");
        begin
            int cyc;
            cyc = 1;
            while (!mc.moving && cyc < 1100) begin step(); cyc++; end
            chk("f_park_cycle", cyc, 1001);
            chk("f_park_dir", int'(mc.dir), 0);
        end
`else
        repeat (5000) step();
        chk("f_still_idle", int'(mc.req_ready), 1);
        chk("f_no_motion", int'(mc.moving), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
